aemb_dwb_sram: RTL and testbench

- Wishbone data-bus responder (slave) that serves the core's data master port: word address, byte selects, strobe, write-enable.
- Contains a single-port on-chip data RAM of 2^AW 32-bit words.
- Supports byte-lane writes, a programmable number of wait states and a registered acknowledge.
- Sits between the core data port and the local memory map; also used as the bench memory model.

---
 rtl/aemb_dwb_sram.sv | 104 ++++++++++
 tb/tb_aemb_dwb_sram.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/aemb_dwb_sram.sv
// rtl/aemb_dwb_sram.sv - Wishbone data-bus SRAM responder with byte lanes and wait states
module aemb_dwb_sram #(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic [29:0] dwb_adr_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_we_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  // The counter is preloaded with WAIT-1 so that ACK is entered WAIT edges after IDLE.
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t        state;
  logic [3:0]    cnt;
  logic [31:0]   mem [2**AW];
  logic [AW-1:0] idx;
  logic          enter_ack;
  logic          wr_en;
  logic          unused_adr;

  // Upper address bits are ignored, so addresses alias modulo the RAM depth.
  assign idx        = dwb_adr_i[AW-1:0];
  assign unused_adr = ^dwb_adr_i[29:AW];

  // The transfer happens on the edge that moves the FSM into ACK.
  always_comb begin
    enter_ack = 1'b0;
    if (dwb_stb_i) begin
      if (state == ST_IDLE && WAIT == 0) begin
        enter_ack = 1'b1;
      end else if (state == ST_WAIT && cnt == 4'd0) begin
        enter_ack = 1'b1;
      end
    end
  end

  // Gating with grst makes sure a write is dropped when reset arrives before it commits.
  assign wr_en = grst & enter_ack & dwb_we_i;

  // Byte-lane write into the RAM. Memory contents are never reset.
  always_ff @(posedge gclk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dwb_sel_i[i]) begin
          mem[idx][8*i +: 8] <= dwb_dat_i[8*i +: 8];
        end
      end
    end
  end

  // Handshake FSM with a registered ack and registered read data.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      dwb_ack_o <= 1'b0;
      dwb_dat_o <= 32'h0;
    end else begin
      dwb_ack_o <= 1'b0;
      if (enter_ack && !dwb_we_i) begin
        dwb_dat_o <= mem[idx];
      end
      case (state)
        ST_IDLE: begin
          if (dwb_stb_i) begin
            if (WAIT == 0) begin
              state     <= ST_ACK;
              dwb_ack_o <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!dwb_stb_i) begin
            state <= ST_IDLE;
          end else if (cnt == 4'd0) begin
            state     <= ST_ACK;
            dwb_ack_o <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_dwb_sram.sv
// tb/tb_aemb_dwb_sram.sv - self-checking bench for aemb_dwb_sram
module tb_aemb_dwb_sram;

  logic        gclk;
  logic        rst0, rst3;
  logic [29:0] adr0, adr3;
  logic [3:0]  sel0, sel3;
  logic [31:0] dati0, dati3;
  logic        we0, we3, stb0, stb3;
  logic [31:0] dato0, dato3;
  logic        ack0, ack3;

  int passed = 0;
  int total  = 0;
  logic [31:0] last0 = 32'h0;

  typedef struct {
    logic        we;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  aemb_dwb_sram #(.AW(10), .WAIT(0)) dut0 (
    .gclk(gclk), .grst(rst0), .dwb_adr_i(adr0), .dwb_sel_i(sel0), .dwb_dat_i(dati0),
    .dwb_we_i(we0), .dwb_stb_i(stb0), .dwb_dat_o(dato0), .dwb_ack_o(ack0)
  );

  aemb_dwb_sram #(.AW(10), .WAIT(3)) dut3 (
    .gclk(gclk), .grst(rst3), .dwb_adr_i(adr3), .dwb_sel_i(sel3), .dwb_dat_i(dati3),
    .dwb_we_i(we3), .dwb_stb_i(stb3), .dwb_dat_o(dato3), .dwb_ack_o(ack3)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One transfer on the zero-wait instance; ack must appear one edge after stb is sampled.
  task automatic xfer0(input vec_t v, input int k);
    @(negedge gclk);
    adr0 = v.adr; sel0 = v.sel; dati0 = v.dat; we0 = v.we; stb0 = 1'b1;
    @(negedge gclk);
    check($sformatf("v%0d ack high", k), {31'b0, ack0}, 32'h1);
    if (!v.we) begin
      check($sformatf("v%0d read data", k), dato0, v.exp);
      last0 = v.exp;
    end else begin
      check($sformatf("v%0d dat_o held on write", k), dato0, last0);
    end
    stb0 = 1'b0;
    @(negedge gclk);
    check($sformatf("v%0d ack one cycle", k), {31'b0, ack0}, 32'h0);
  endtask

  // One transfer on the WAIT=3 instance with a bounded wait for ack.
  task automatic xfer3(input string name, input logic we, input logic [29:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat, input logic [31:0] exp);
    int n;
    bit got;
    @(negedge gclk);
    adr3 = adr; sel3 = sel; dati3 = dat; we3 = we; stb3 = 1'b1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge gclk);
      n++;
      if (ack3) got = 1;
    end
    check({name, " latency"}, 32'(n), 32'd4);
    if (!we) check({name, " data"}, dato3, exp);
    stb3 = 1'b0;
    @(negedge gclk);
    check({name, " ack drop"}, {31'b0, ack3}, 32'h0);
  endtask

  initial begin
    int acks;
    rst0 = 1'b0; rst3 = 1'b0;
    adr0 = '0; sel0 = '0; dati0 = '0; we0 = 1'b0; stb0 = 1'b0;
    adr3 = '0; sel3 = '0; dati3 = '0; we3 = 1'b0; stb3 = 1'b0;

    vecs[0]  = '{1'b1, 30'h004, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 30'h004, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 30'h010, 4'hF, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 30'h010, 4'h8, 32'hAA000000, 32'h0};
    vecs[4]  = '{1'b0, 30'h010, 4'h0, 32'h0,        32'hAA223344};
    vecs[5]  = '{1'b1, 30'h010, 4'h3, 32'h0000BBCC, 32'h0};
    vecs[6]  = '{1'b0, 30'h010, 4'hF, 32'h0,        32'hAA22BBCC};
    vecs[7]  = '{1'b1, 30'h001, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[8]  = '{1'b0, 30'h401, 4'hF, 32'h0,        32'hCAFEF00D};
    vecs[9]  = '{1'b1, 30'h004, 4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[10] = '{1'b0, 30'h004, 4'h1, 32'h0,        32'hDEADBEEF};
    vecs[11] = '{1'b0, 30'h010, 4'hF, 32'h0,        32'hAA22BBCC};

    repeat (3) @(negedge gclk);
    rst0 = 1'b1; rst3 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge gclk);
      check($sformatf("idle cycle %0d", i),
            {30'b0, ack0, ack3}, 32'h0);
      check($sformatf("idle dat cycle %0d", i), dato0 | dato3, 32'h0);
    end

    for (int i = 0; i < 12; i++) xfer0(vecs[i], i);

    xfer3("w3 preload", 1'b1, 30'h020, 4'hF, 32'h12345678, 32'h0);
    xfer3("w3 read", 1'b0, 30'h020, 4'hF, 32'h0, 32'h12345678);

    // Back-to-back with stb held: acks at negedge 4 and 9 only.
    @(negedge gclk);
    adr3 = 30'h020; we3 = 1'b0; sel3 = 4'hF; stb3 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge gclk);
      check($sformatf("b2b ack n=%0d", n), {31'b0, ack3}, (n == 4 || n == 9) ? 32'h1 : 32'h0);
      if (n == 9) stb3 = 1'b0;
    end

    // Abort in WAIT: no ack and no write.
    @(negedge gclk);
    adr3 = 30'h020; we3 = 1'b1; sel3 = 4'hF; dati3 = 32'hFFFFFFFF; stb3 = 1'b1;
    acks = 0;
    repeat (2) begin
      @(negedge gclk);
      if (ack3) acks++;
    end
    stb3 = 1'b0;
    repeat (6) begin
      @(negedge gclk);
      if (ack3) acks++;
    end
    check("abort no ack", 32'(acks), 32'd0);
    xfer3("abort read", 1'b0, 30'h020, 4'hF, 32'h0, 32'h12345678);

    // Reset pulse in WAIT: write dropped, outputs cleared, FSM back in IDLE.
    @(negedge gclk);
    adr3 = 30'h020; we3 = 1'b1; sel3 = 4'hF; dati3 = 32'h0BADF00D; stb3 = 1'b1;
    repeat (2) @(negedge gclk);
    rst3 = 1'b0; stb3 = 1'b0;
    #1;
    check("reset ack", {31'b0, ack3}, 32'h0);
    check("reset dat_o", dato3, 32'h0);
    @(negedge gclk);
    rst3 = 1'b1;
    xfer3("post-reset read", 1'b0, 30'h020, 4'hF, 32'h0, 32'h12345678);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
